cla_shift_add_mul: RTL

//  Sequential unsigned WIDTHxWIDTH shift-add multiplier driving the team's 8-bit carry-lookahead adder.

---
 rtl/cla_mul_pkg.sv | 22 ++
 rtl/cla_add8.sv | 27 ++
 rtl/cla_shift_add_mul.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cla_mul_pkg.sv
// cla_mul_pkg: shared state encoding, width constants and the CLA carry helper for the shift-add multiplier
package cla_mul_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

   // Carry into bit i+1, expanded as a flat generate/propagate sum of products.
   function automatic logic cla_carry(input int i, input logic [7:0] g, input logic [7:0] p, input logic cin);
      logic t;
      logic pp;
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
         t  = t | (pp & g[j]);
         pp = pp & p[j];
      end
      return t | (pp & cin);
   endfunction

endpackage

// File: rtl/cla_add8.sv
// cla_add8: 8-bit combinational carry-lookahead adder with per-bit generate/propagate
module cla_add8
   import cla_mul_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_carry
      assign c[i+1] = cla_carry(i, g, p, cin);
   end

   assign s    = p ^ c[7:0];
   assign cout = c[8];

endmodule

// File: rtl/cla_shift_add_mul.sv
// cla_shift_add_mul: sequential unsigned shift-add multiplier on cla_add8; define MUL_EARLY_TERM_EN to stop once no multiplier bits remain
module cla_shift_add_mul
   import cla_mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     phi_q, phi_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [WIDTH-1:0]     phi_n, q_n, add_s;
   logic                 add_c;
   logic [CNT_W-1:0]     cnt_n;
`ifdef MUL_EARLY_TERM_EN
   logic [WIDTH-1:0]     r_q, r_d;
`endif

   cla_add8 u_add (
      .a    (phi_q),
      .b    (a_q),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_c)
   );

   assign {phi_n, q_n} = q_q[0] ? {add_c, add_s, q_q[WIDTH-1:1]} : {1'b0, phi_q, q_q[WIDTH-1:1]};
   assign cnt_n        = cnt_q + CNT_W'(1);
   assign in_ready     = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign out_valid    = out_valid_q;
   assign product      = product_q;

   // Next-state: operand load on accept, one add/shift step per RUN cycle, hold result in DONE
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      phi_d       = phi_q;
      q_d         = q_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      product_d   = product_q;
`ifdef MUL_EARLY_TERM_EN
      r_d         = r_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               phi_d   = '0;
               q_d     = b;
               cnt_d   = '0;
               state_d = RUN;
`ifdef MUL_EARLY_TERM_EN
               r_d     = b;
               if (b == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  product_d   = '0;
               end
`endif
            end
         end
         RUN: begin
            phi_d = phi_n;
            q_d   = q_n;
            cnt_d = cnt_n;
`ifdef MUL_EARLY_TERM_EN
            r_d   = r_q >> 1;
            if (cnt_n == CNT_MAX || r_d == '0) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               product_d   = {phi_n, q_n} >> (CNT_MAX - cnt_n);
            end
`else
            if (cnt_n == CNT_MAX) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               product_d   = {phi_n, q_n};
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         phi_q       <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
`ifdef MUL_EARLY_TERM_EN
         r_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         phi_q       <= phi_d;
         q_q         <= q_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
`ifdef MUL_EARLY_TERM_EN
         r_q         <= r_d;
`endif
      end
   end

endmodule
